// File: rtl/ws_systolic_pkg.sv
// rtl/ws_systolic_pkg.sv - shared constants for the weight-stationary systolic array
//
// Purpose: Op_sel encodings and default word sizes used by ws_pe and ws_systolic_array.
// Ports:   none (package).
// Config:  WS_SYSTOLIC_SAT_EN (consumed by ws_pe) selects saturating accumulation.
package ws_systolic_pkg;

  localparam logic PRELOAD_OP = 1'b0;
  localparam logic CONV_OP    = 1'b1;

  localparam int DEFAULT_IN_WORD_SIZE  = 16;
  localparam int DEFAULT_OUT_WORD_SIZE = 16;

endpackage

// File: rtl/ws_pe.sv
// rtl/ws_pe.sv - single weight-stationary processing element (weight/fmap/psum + MAC)
//
// Purpose: holds one stationary weight, forwards the fmap word downward and the
//          weight rightward (preload), and accumulates west + north*weight (conv).
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   op_sel         PRELOAD_OP shifts weights, CONV_OP computes
//   north_fmap     fmap word from the PE above (or the array input)
//   west_psum      partial sum from the PE to the left (or Result_in)
//   west_weight    weight from the PE to the left (or kernel_in)
//   weight         stationary weight register
//   fmap_r         registered fmap, feeds the PE below
//   psum           registered partial sum, feeds the PE to the right
// Config: WS_SYSTOLIC_SAT_EN defined -> product and sum saturate at all-ones;
//         undefined -> both wrap modulo 2^out_word_size.
module ws_pe
  import ws_systolic_pkg::*;
#(
  parameter int in_word_size  = DEFAULT_IN_WORD_SIZE,
  parameter int out_word_size = DEFAULT_OUT_WORD_SIZE
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     op_sel,
  input  logic [in_word_size-1:0]  north_fmap,
  input  logic [out_word_size-1:0] west_psum,
  input  logic [in_word_size-1:0]  west_weight,
  output logic [in_word_size-1:0]  weight,
  output logic [in_word_size-1:0]  fmap_r,
  output logic [out_word_size-1:0] psum
);

  // Product is formed wide enough for both the full product and the psum width,
  // so the saturation compare never loses high bits.
  localparam int PW = (2 * in_word_size > out_word_size) ? 2 * in_word_size : out_word_size;

  logic [PW-1:0]            prod;
  logic [out_word_size-1:0] mac_next;

  assign prod = PW'(north_fmap) * PW'(weight);

`ifdef WS_SYSTOLIC_SAT_EN
  localparam logic [out_word_size-1:0] PSUM_MAX = '1;

  logic [out_word_size-1:0] prod_clip;
  logic [out_word_size:0]   sum_ext;

  always_comb begin
    prod_clip = (prod > PW'(PSUM_MAX)) ? PSUM_MAX : out_word_size'(prod);
    sum_ext   = {1'b0, west_psum} + {1'b0, prod_clip};
    mac_next  = sum_ext[out_word_size] ? PSUM_MAX : sum_ext[out_word_size-1:0];
  end
`else
  always_comb begin
    mac_next = west_psum + out_word_size'(prod);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      weight <= '0;
      fmap_r <= '0;
      psum   <= '0;
    end else if (op_sel == CONV_OP) begin
      fmap_r <= north_fmap;
      psum   <= mac_next;
    end else begin
      // Preload: weights shift right, datapath is flushed so stale partial
      // sums cannot leak into the next convolution.
      weight <= west_weight;
      fmap_r <= '0;
      psum   <= '0;
    end
  end

endmodule

// File: rtl/ws_systolic_array.sv
// rtl/ws_systolic_array.sv - row x column weight-stationary systolic MAC array
//
// Purpose: grid of ws_pe; fmap flows top to bottom, weights and partial sums
//          flow left to right. Caller skews fmap lanes by one cycle per column.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   fmap_in[c]    fmap word entering the top of column c
//   kernel_in[r]  weight word entering the left of row r during preload
//   Result_in[r]  partial sum entering the left of row r
//   Op_sel        0 = preload weights, 1 = convolution
//   fmap_out[c]   fmap register of PE(row-1,c)
//   kernel_out[r] weight register of PE(r,column-1)
//   Result_out[r] psum register of PE(r,column-1)
// Config: WS_SYSTOLIC_SAT_EN selects saturating accumulation inside ws_pe.
module ws_systolic_array
  import ws_systolic_pkg::*;
#(
  parameter int in_word_size  = DEFAULT_IN_WORD_SIZE,
  parameter int out_word_size = DEFAULT_OUT_WORD_SIZE,
  parameter int row           = 1,
  parameter int column        = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [in_word_size-1:0]  fmap_in    [column],
  input  logic [in_word_size-1:0]  kernel_in  [row],
  input  logic [out_word_size-1:0] Result_in  [row],
  input  logic                     Op_sel,
  output logic [in_word_size-1:0]  fmap_out   [column],
  output logic [in_word_size-1:0]  kernel_out [row],
  output logic [out_word_size-1:0] Result_out [row]
);

  logic [in_word_size-1:0]  weight_a [row][column];
  logic [in_word_size-1:0]  fmap_a   [row][column];
  logic [out_word_size-1:0] psum_a   [row][column];

  for (genvar r = 0; r < row; r++) begin : g_row
    for (genvar c = 0; c < column; c++) begin : g_col
      logic [in_word_size-1:0]  north;
      logic [out_word_size-1:0] west_p;
      logic [in_word_size-1:0]  west_w;

      if (r == 0) begin : g_top
        assign north = fmap_in[c];
      end else begin : g_inner
        assign north = fmap_a[r-1][c];
      end

      if (c == 0) begin : g_left
        assign west_p = Result_in[r];
        assign west_w = kernel_in[r];
      end else begin : g_mid
        assign west_p = psum_a[r][c-1];
        assign west_w = weight_a[r][c-1];
      end

      ws_pe #(
        .in_word_size (in_word_size),
        .out_word_size(out_word_size)
      ) u_pe (
        .clk        (clk),
        .rst        (rst),
        .op_sel     (Op_sel),
        .north_fmap (north),
        .west_psum  (west_p),
        .west_weight(west_w),
        .weight     (weight_a[r][c]),
        .fmap_r     (fmap_a[r][c]),
        .psum       (psum_a[r][c])
      );
    end

    assign kernel_out[r] = weight_a[r][column-1];
    assign Result_out[r] = psum_a[r][column-1];
  end

  for (genvar c = 0; c < column; c++) begin : g_fout
    assign fmap_out[c] = fmap_a[row-1][c];
  end

endmodule

// File: tb/tb_ws_systolic_array.sv
// tb/tb_ws_systolic_array.sv - scoreboard bench for ws_systolic_array (row=2, column=4)
module tb_ws_systolic_array;

  localparam int ROW = 2;
  localparam int COL = 4;
  localparam int IW  = 16;
  localparam int OW  = 16;

`ifdef WS_SYSTOLIC_SAT_EN
  localparam logic [OW-1:0] WRAP_PROD = 16'hFFFF;
  localparam logic [OW-1:0] WRAP_SUM  = 16'hFFFF;
`else
  localparam logic [OW-1:0] WRAP_PROD = 16'hFFFE;
  localparam logic [OW-1:0] WRAP_SUM  = 16'h0001;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [IW-1:0] fmap_in    [COL];
  logic [IW-1:0] kernel_in  [ROW];
  logic [OW-1:0] Result_in  [ROW];
  logic          Op_sel = 1'b0;
  logic [IW-1:0] fmap_out   [COL];
  logic [IW-1:0] kernel_out [ROW];
  logic [OW-1:0] Result_out [ROW];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int            due;
    int            lane;
    logic [OW-1:0] val;
  } exp_t;

  exp_t sb[$];

  ws_systolic_array #(
    .in_word_size (IW),
    .out_word_size(OW),
    .row          (ROW),
    .column       (COL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .fmap_in   (fmap_in),
    .kernel_in (kernel_in),
    .Result_in (Result_in),
    .Op_sel    (Op_sel),
    .fmap_out  (fmap_out),
    .kernel_out(kernel_out),
    .Result_out(Result_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: each expected Result_out word is checked at the negedge after its due edge.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        total++;
        if (Result_out[sb[i].lane] !== sb[i].val) begin
          bad++;
          $display("FAIL sb_result lane=%0d edge=%0d got=%h exp=%h",
                   sb[i].lane, cyc, Result_out[sb[i].lane], sb[i].val);
        end
        sb.delete(i);
      end else if (sb[i].due < cyc) begin
        total++;
        bad++;
        $display("FAIL sb_missed lane=%0d due=%0d got=none exp=%h", sb[i].lane, sb[i].due, sb[i].val);
        sb.delete(i);
      end
    end
  end

  function automatic void expect_at(input int due, input int lane, input logic [OW-1:0] v);
    exp_t e;
    e.due  = due;
    e.lane = lane;
    e.val  = v;
    sb.push_back(e);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    for (int c = 0; c < COL; c++) fmap_in[c] = '0;
    for (int r = 0; r < ROW; r++) begin
      kernel_in[r] = '0;
      Result_in[r] = '0;
    end
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    Op_sel = 1'b1;
    for (int c = 0; c < COL; c++) fmap_in[c] = 16'h1111;
    for (int r = 0; r < ROW; r++) begin
      kernel_in[r] = 16'h2222;
      Result_in[r] = 16'h3333;
    end
    tick();
    tick();
    for (int r = 0; r < ROW; r++) begin
      total++;
      if (kernel_out[r] !== '0) begin
        bad++;
        $display("FAIL reset_kernel_out r=%0d got=%h exp=0", r, kernel_out[r]);
      end
      total++;
      if (Result_out[r] !== '0) begin
        bad++;
        $display("FAIL reset_result_out r=%0d got=%h exp=0", r, Result_out[r]);
      end
    end
    for (int c = 0; c < COL; c++) begin
      total++;
      if (fmap_out[c] !== '0) begin
        bad++;
        $display("FAIL reset_fmap_out c=%0d got=%h exp=0", c, fmap_out[c]);
      end
    end
    rst = 1'b0;
    clear_inputs();
  endtask

  task automatic test_preload();
    logic [IW-1:0] feed0 [4];
    logic [IW-1:0] exp0, exp1;
    feed0 = '{16'd5, 16'd4, 16'd2, 16'd3};
    Op_sel = 1'b0;
    for (int k = 0; k < 4; k++) begin
      kernel_in[0] = feed0[k];
      kernel_in[1] = IW'(k + 1);
      tick();
      exp0 = (k < 3) ? 16'd0 : 16'd5;
      exp1 = (k < 3) ? 16'd0 : 16'd1;
      total++;
      if (kernel_out[0] !== exp0) begin
        bad++;
        $display("FAIL preload_kernel_out0 k=%0d got=%h exp=%h", k, kernel_out[0], exp0);
      end
      total++;
      if (kernel_out[1] !== exp1) begin
        bad++;
        $display("FAIL preload_kernel_out1 k=%0d got=%h exp=%h", k, kernel_out[1], exp1);
      end
    end
    clear_inputs();
  endtask

  // Row0 weights 3,2,4,5 and row1 weights 4,3,2,1; fmap 1..4 gives 0x27 and 0x14.
  task automatic test_conv();
    int e;
    Op_sel = 1'b1;
    e = cyc + 1;
    expect_at(e + 3, 0, 16'h0027);
    expect_at(e + 4, 1, 16'h0014);
    for (int k = 0; k < 7; k++) begin
      for (int c = 0; c < COL; c++) fmap_in[c] = (k == c) ? IW'(c + 1) : '0;
      tick();
    end
    total++;
    if (kernel_out[0] !== 16'd5) begin
      bad++;
      $display("FAIL conv_weight_hold got=%h exp=0005", kernel_out[0]);
    end
    clear_inputs();
  endtask

  // Two overlapping waves: wave A (fmap c+1) with psum bias, wave B (fmap 2(c+1)) one cycle later.
  task automatic test_back_to_back();
    int e;
    Op_sel = 1'b1;
    e = cyc + 1;
    expect_at(e + 3, 0, 16'h0127);
    expect_at(e + 4, 0, 16'h024E);
    expect_at(e + 4, 1, 16'h0024);
    expect_at(e + 5, 1, 16'h0048);
    for (int k = 0; k < 7; k++) begin
      for (int c = 0; c < COL; c++)
        fmap_in[c] = (k == c) ? IW'(c + 1) : (k == c + 1) ? IW'(2 * (c + 1)) : '0;
      Result_in[0] = (k == 0) ? 16'h0100 : (k == 1) ? 16'h0200 : '0;
      Result_in[1] = (k == 1) ? 16'h0010 : (k == 2) ? 16'h0020 : '0;
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_wrap();
    int e;
    Op_sel = 1'b0;
    for (int k = 0; k < 4; k++) begin
      kernel_in[0] = (k == 3) ? 16'hFFFF : '0;
      kernel_in[1] = '0;
      tick();
    end
    total++;
    if (kernel_out[0] !== '0) begin
      bad++;
      $display("FAIL wrap_preload_kernel_out got=%h exp=0", kernel_out[0]);
    end
    clear_inputs();
    Op_sel = 1'b1;
    e = cyc + 1;
    expect_at(e + 3, 0, WRAP_PROD);
    expect_at(e + 4, 0, WRAP_SUM);
    expect_at(e + 4, 1, 16'h0000);
    for (int k = 0; k < 7; k++) begin
      fmap_in[0]   = (k < 2) ? 16'd2 : '0;
      Result_in[0] = (k == 1) ? 16'd3 : '0;
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid_conv();
    int e;
    Op_sel = 1'b1;
    for (int c = 0; c < COL; c++) fmap_in[c] = 16'd9;
    Result_in[0] = 16'h0500;
    Result_in[1] = 16'h0600;
    tick();
    tick();
    rst = 1'b1;
    tick();
    for (int r = 0; r < ROW; r++) begin
      total++;
      if (Result_out[r] !== '0 || kernel_out[r] !== '0) begin
        bad++;
        $display("FAIL midrst_row_out r=%0d got=%h/%h exp=0/0", r, Result_out[r], kernel_out[r]);
      end
    end
    for (int c = 0; c < COL; c++) begin
      total++;
      if (fmap_out[c] !== '0) begin
        bad++;
        $display("FAIL midrst_fmap_out c=%0d got=%h exp=0", c, fmap_out[c]);
      end
    end
    rst = 1'b0;
    e = cyc + 1;
    expect_at(e + 3, 0, 16'h1234);
    expect_at(e + 4, 0, 16'h0042);
    expect_at(e + 4, 1, 16'h0055);
    for (int k = 0; k < 7; k++) begin
      for (int c = 0; c < COL; c++) fmap_in[c] = 16'd7;
      Result_in[0] = (k == 0) ? 16'h1234 : (k == 1) ? 16'h0042 : '0;
      Result_in[1] = (k == 1) ? 16'h0055 : '0;
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_fmap_path();
    Op_sel = 1'b1;
    clear_inputs();
    tick();
    tick();
    for (int c = 0; c < COL; c++) fmap_in[c] = 16'h00AB;
    tick();
    clear_inputs();
    for (int c = 0; c < COL; c++) begin
      total++;
      if (fmap_out[c] !== '0) begin
        bad++;
        $display("FAIL fmap_early c=%0d got=%h exp=0", c, fmap_out[c]);
      end
    end
    tick();
    for (int c = 0; c < COL; c++) begin
      total++;
      if (fmap_out[c] !== 16'h00AB) begin
        bad++;
        $display("FAIL fmap_two_edges c=%0d got=%h exp=00ab", c, fmap_out[c]);
      end
    end
    tick();
    for (int c = 0; c < COL; c++) begin
      total++;
      if (fmap_out[c] !== '0) begin
        bad++;
        $display("FAIL fmap_gone c=%0d got=%h exp=0", c, fmap_out[c]);
      end
    end
    // Switching to preload flushes fmap and psum on the very edge it is sampled.
    for (int c = 0; c < COL; c++) fmap_in[c] = 16'h00CD;
    Result_in[0] = 16'h0777;
    tick();
    tick();
    Op_sel = 1'b0;
    tick();
    for (int c = 0; c < COL; c++) begin
      total++;
      if (fmap_out[c] !== '0) begin
        bad++;
        $display("FAIL preload_flush_fmap c=%0d got=%h exp=0", c, fmap_out[c]);
      end
    end
    total++;
    if (Result_out[0] !== '0) begin
      bad++;
      $display("FAIL preload_flush_psum got=%h exp=0", Result_out[0]);
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_preload();
    test_conv();
    test_back_to_back();
    test_wrap();
    test_reset_mid_conv();
    test_fmap_path();
    for (int i = 0; i < 20 && sb.size() > 0; i++) tick();
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL sb_drain pending=%0d exp=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
